satatrn_txsegment: RTL and testbench
====================================

// Module: satatrn_txsegment
// PURPOSE
//  Transport-layer TX sequencer, PHY clock domain, placed ahead of the TX FIS arbiter's data port.
//  Takes one host-to-device DMA write of i_len dwords and splits it into DATA FIS payload segments
//  of at most 2**LGMAXFIS dwords.
//  Each segment is released only after a DMA Activate from the device. While a segment is released,
//  o_txgate drives the arbiter gate; the arbiter prepends the 8'h46 header.
// PARAMETERS
//  LGMAXFIS  11  log2 of max payload dwords per DATA FIS (2048)
//  LGLEN     16  width of transfer length in dwords
// PORTS
//  i_phy_clk       in   1          clock
//  i_phy_reset_n   in   1          reset, asynchronous, active-low
//  i_start         in   1          begin transfer (honoured only in IDLE)
//  i_len           in   LGLEN      transfer length, dwords, sampled with i_start
//  i_dma_activate  in   1          one-cycle pulse: device DMA Activate received
//  i_abort         in   1          abort current transfer
//  o_busy          out  1          transfer in progress (state != IDLE)
//  o_done          out  1          one-cycle pulse: transfer completed normally
//  o_err           out  1          one-cycle pulse: zero length or abort
//  o_txgate        out  1          registered; high only in SEND
//  s_valid/s_ready/s_data  in/out/in  1/1/32   payload source stream
//  m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/32/1  to arbiter data port
//  o_frame_count   out  16         segments sent (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; o_busy, o_done, o_err, o_txgate, abort_pend, counters = 0.
//  m_valid = (state==SEND) && s_valid; s_ready = (state==SEND) && m_ready; m_data = s_data (combinational).
//  Beat = m_valid && m_ready; only beats advance counters.
//  remaining: LGLEN bits.
//  seg_left: LGMAXFIS+1 bits.
//  m_last = (seg_left == 1).
//  IDLE:
//   - i_start and i_len != 0: remaining <= i_len; go to WAIT_ACT.
//   - i_start and i_len == 0: o_err pulse next cycle; stay in IDLE.
//  WAIT_ACT (o_txgate = 0):
//   - i_dma_activate: seg_left <= min(remaining, 2**LGMAXFIS); o_txgate <= 1; go to SEND.
//   - Activate pulses in any other state are ignored.
//  SEND: each beat decrements seg_left and remaining. On the m_last beat, o_txgate <= 0 and:
//   - if abort_pend: go to IDLE, o_err pulse;
//   - else if remaining == 1: go to IDLE, o_done pulse;
//   - else: go to WAIT_ACT.
//  Abort:
//   - IDLE: ignored.
//   - WAIT_ACT: go to IDLE next cycle with an o_err pulse; abort beats a simultaneous activate.
//   - SEND: sets abort_pend. The segment still completes to m_last so the frame ends cleanly.
//     abort_pend clears on entry to IDLE.
//  i_start while o_busy is ignored; i_len is not resampled.
//  Latency: o_txgate rises the cycle after the activate pulse; the first beat can occur in that same cycle.
//  Done/err pulses appear the cycle after the terminating beat or event.
//  Async reset mid-SEND: all state clears immediately; a partial frame is the downstream's problem.
// CONFIGURATION
//  SATA_TXSEG_STATS_EN defined:
//   - o_frame_count increments on every m_last beat, wraps at 16'hFFFF -> 0.
//   - Reset to 0 by reset only.
//  Undefined: o_frame_count tied to 16'h0; no counter logic.
// TESTING
//  1. LGMAXFIS=11, start len=5, one activate -> five beats, m_last on the 5th, o_txgate high
//     exactly during SEND, o_done pulse.
//  2. LGMAXFIS=3, len=20, three activates -> segments of 8, 8 and 4 beats. o_txgate low between
//     segments until each activate; o_done after the final beat only.
//  3. LGMAXFIS=3, len=8, m_ready toggled randomly, s_valid gapped -> data order preserved,
//     8 beats, no beat while ready low.
//  4. len=0 -> o_err pulse, o_busy stays 0. i_start during SEND -> ignored, count unchanged.
//  5. LGMAXFIS=3, len=20, abort after beat 3 of seg 1 -> seg 1 finishes 8 beats with m_last,
//     then IDLE + o_err, no o_done. Abort in WAIT_ACT with simultaneous activate -> IDLE, no SEND.
//  6. With SATA_TXSEG_STATS_EN, test 2 -> o_frame_count=3. Reset asserted mid-SEND ->
//     all outputs 0 immediately, count 0.

Source files
------------

// File: rtl/satatrn_txsegment.sv
// Transport TX sequencer: splits one DMA write into DATA FIS segments, each gated by DMA Activate.
// Optional frame statistics counter enabled by SATA_TXSEG_STATS_EN.
module satatrn_txsegment #(
    parameter int LGMAXFIS = 11,
    parameter int LGLEN    = 16
) (
    input  logic             i_phy_clk,
    input  logic             i_phy_reset_n,
    input  logic             i_start,
    input  logic [LGLEN-1:0] i_len,
    input  logic             i_dma_activate,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_txgate,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic [15:0]      o_frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACT,
        SEND
    } state_t;

    localparam logic [LGLEN-1:0]  MAXSEG  = LGLEN'(2 ** LGMAXFIS);
    localparam logic [LGLEN-1:0]  LEN_ONE = 1;
    localparam logic [LGMAXFIS:0] SEG_ONE = 1;

    state_t              state;
    logic [LGLEN-1:0]    remaining;
    logic [LGMAXFIS:0]   seg_left;
    logic                abort_pend;
    logic                beat;
    logic                in_send;

    assign in_send = (state == SEND);
    assign m_valid = in_send && s_valid;
    assign s_ready = in_send && m_ready;
    assign m_data  = s_data;
    assign m_last  = (seg_left == SEG_ONE);
    assign beat    = m_valid && m_ready;

    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            state      <= IDLE;
            remaining  <= '0;
            seg_left   <= '0;
            abort_pend <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_txgate   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (i_start) begin
                        if (i_len != '0) begin
                            remaining <= i_len;
                            state     <= WAIT_ACT;
                            o_busy    <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                WAIT_ACT: begin
                    // Abort wins over an activate arriving in the same cycle
                    if (i_abort || abort_pend) begin
                        state      <= IDLE;
                        o_busy     <= 1'b0;
                        o_err      <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (i_dma_activate) begin
                        seg_left <= (remaining > MAXSEG) ? MAXSEG[LGMAXFIS:0]
                                                         : remaining[LGMAXFIS:0];
                        o_txgate <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (i_abort)
                        abort_pend <= 1'b1;
                    if (beat) begin
                        seg_left  <= seg_left - SEG_ONE;
                        remaining <= remaining - LEN_ONE;
                        // A pending abort still lets the frame end on m_last
                        if (m_last) begin
                            o_txgate <= 1'b0;
                            if (abort_pend) begin
                                state      <= IDLE;
                                o_busy     <= 1'b0;
                                o_err      <= 1'b1;
                                abort_pend <= 1'b0;
                            end else if (remaining == LEN_ONE) begin
                                state      <= IDLE;
                                o_busy     <= 1'b0;
                                o_done     <= 1'b1;
                                abort_pend <= 1'b0;
                            end else begin
                                state <= WAIT_ACT;
                            end
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_busy   <= 1'b0;
                    o_txgate <= 1'b0;
                end
            endcase
        end
    end

`ifdef SATA_TXSEG_STATS_EN
    logic [15:0] frame_count;

    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n)
            frame_count <= '0;
        else if (beat && m_last)
            frame_count <= frame_count + 16'd1;
    end

    assign o_frame_count = frame_count;
`else
    assign o_frame_count = 16'h0;
`endif

endmodule

// File: tb/tb_satatrn_txsegment.sv
// Self-checking bench for satatrn_txsegment (LGMAXFIS=3): vector table plus corner sequences,
// beat data/last checked against a scoreboard queue.
module tb_satatrn_txsegment;

    localparam int LGMAXFIS = 3;
    localparam int LGLEN    = 16;
    localparam int SEGMAX   = 8;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [LGLEN-1:0] i_len;
    logic             i_dma_activate;
    logic             i_abort;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic             o_txgate;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_last;
    logic [15:0]      o_frame_count;

    satatrn_txsegment #(
        .LGMAXFIS(LGMAXFIS),
        .LGLEN   (LGLEN)
    ) dut (
        .i_phy_clk     (clk),
        .i_phy_reset_n (rst_n),
        .i_start       (i_start),
        .i_len         (i_len),
        .i_dma_activate(i_dma_activate),
        .i_abort       (i_abort),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_txgate      (o_txgate),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .o_frame_count (o_frame_count)
    );

    typedef struct {
        int len;
        bit rnd;
        int segs;
        int done;
        int err;
    } vec_t;

    int          tests;
    int          fails;
    logic [32:0] q[$];
    int          src_idx;
    int          exp_idx;
    bit          beat_seen;
    bit          rnd_mode;
    int          n_done;
    int          n_err;
    int          n_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_data = 32'hA500_0000 + 32'(src_idx);

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source and sink pacing
    always @(posedge clk) begin
        if (beat_seen) begin
            src_idx++;
            beat_seen = 1'b0;
        end
        #1;
        s_valid = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor / scoreboard sink
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", {m_last, m_data}, 0);
                end else begin
                    logic [32:0] e;
                    e = q.pop_front();
                    check("beat_data_last", {m_last, m_data}, e);
                end
                beat_seen = 1'b1;
                if (m_last) n_last++;
            end
            if (m_valid && !o_txgate)
                check("valid_without_gate", o_txgate, 1);
            if (o_busy)
                check("s_ready", s_ready, o_txgate & m_ready);
            if (o_done) n_done++;
            if (o_err) n_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_seg(input int n);
        for (int k = 0; k < n; k++) begin
            q.push_back({(k == n - 1), 32'hA500_0000 + 32'(exp_idx)});
            exp_idx++;
        end
    endtask

    task automatic wait_q(input int lvl);
        for (int c = 0; c < 400 && q.size() > lvl; c++) tick();
        check("timeout_wait_beats", q.size() > lvl, 0);
    endtask

    task automatic start(input int len);
        i_start = 1'b1;
        i_len   = LGLEN'(len);
        tick();
        i_start = 1'b0;
        i_len   = '0;
    endtask

    task automatic activate();
        i_dma_activate = 1'b1;
        tick();
        i_dma_activate = 1'b0;
        check("gate_after_act", o_txgate, 1);
    endtask

    task automatic run_xfer(input int len);
        int rem;
        int sz;
        start(len);
        if (len == 0) begin
            check("busy_len0", o_busy, 0);
            tick();
            check("busy_len0_later", o_busy, 0);
        end else begin
            check("busy_started", o_busy, 1);
            rem = len;
            while (rem > 0) begin
                sz = (rem > SEGMAX) ? SEGMAX : rem;
                push_seg(sz);
                tick();
                tick();
                check("gate_waits_act", o_txgate, 0);
                activate();
                wait_q(0);
                rem -= sz;
                check("gate_low_after_seg", o_txgate, 0);
                check("done_timing", o_done, (rem == 0) ? 1 : 0);
            end
            check("busy_end", o_busy, 0);
        end
        tick();
    endtask

    initial begin
        vec_t vecs[7];
        int d0, e0, l0;
        vecs[0] = '{len: 5,  rnd: 0, segs: 1, done: 1, err: 0};
        vecs[1] = '{len: 20, rnd: 0, segs: 3, done: 1, err: 0};
        vecs[2] = '{len: 8,  rnd: 1, segs: 1, done: 1, err: 0};
        vecs[3] = '{len: 0,  rnd: 0, segs: 0, done: 0, err: 1};
        vecs[4] = '{len: 9,  rnd: 1, segs: 2, done: 1, err: 0};
        vecs[5] = '{len: 1,  rnd: 0, segs: 1, done: 1, err: 0};
        vecs[6] = '{len: 16, rnd: 1, segs: 2, done: 1, err: 0};

        tests = 0; fails = 0;
        src_idx = 0; exp_idx = 0; beat_seen = 1'b0; rnd_mode = 1'b0;
        n_done = 0; n_err = 0; n_last = 0;
        rst_n = 1'b0; i_start = 1'b0; i_len = '0;
        i_dma_activate = 1'b0; i_abort = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0;

        tick();
        tick();
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_gate", o_txgate, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_fcount", o_frame_count, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            rnd_mode = vecs[i].rnd;
            d0 = n_done; e0 = n_err; l0 = n_last;
            run_xfer(vecs[i].len);
            check($sformatf("v%0d_done_cnt", i), n_done - d0, vecs[i].done);
            check($sformatf("v%0d_err_cnt", i), n_err - e0, vecs[i].err);
            check($sformatf("v%0d_seg_cnt", i), n_last - l0, vecs[i].segs);
        end
        rnd_mode = 1'b0;

        // i_start during SEND is ignored
        d0 = n_done; l0 = n_last;
        start(5);
        push_seg(5);
        tick();
        activate();
        i_start = 1'b1;
        i_len = 16'd3;
        tick();
        i_start = 1'b0;
        i_len = '0;
        wait_q(0);
        check("ign_start_done", o_done, 1);
        tick(); tick(); tick();
        check("ign_start_idle", o_busy, 0);
        check("ign_start_done_cnt", n_done - d0, 1);
        check("ign_start_segs", n_last - l0, 1);

        // Abort after beat 3 of the first segment
        d0 = n_done; e0 = n_err; l0 = n_last;
        start(20);
        push_seg(8);
        tick();
        activate();
        wait_q(5);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        wait_q(0);
        check("abort_err", o_err, 1);
        check("abort_no_done", o_done, 0);
        check("abort_busy", o_busy, 0);
        tick(); tick(); tick();
        check("abort_done_cnt", n_done - d0, 0);
        check("abort_err_cnt", n_err - e0, 1);
        check("abort_segs", n_last - l0, 1);
        check("abort_stays_idle", o_busy, 0);

        // Abort and activate together in WAIT_ACT
        e0 = n_err; l0 = n_last;
        start(20);
        i_abort = 1'b1;
        i_dma_activate = 1'b1;
        tick();
        i_abort = 1'b0;
        i_dma_activate = 1'b0;
        check("wabort_busy", o_busy, 0);
        check("wabort_err", o_err, 1);
        check("wabort_gate", o_txgate, 0);
        tick(); tick(); tick();
        check("wabort_err_cnt", n_err - e0, 1);
        check("wabort_no_beats", n_last - l0, 0);

        // Abort in IDLE is ignored
        e0 = n_err;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        check("idle_abort_err", n_err - e0, 0);

        // Frame counter after a fresh reset and a 3-segment transfer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_xfer(20);
`ifdef SATA_TXSEG_STATS_EN
        check("fcount_3seg", o_frame_count, 3);
`else
        check("fcount_3seg", o_frame_count, 0);
`endif

        // Asynchronous reset in the middle of SEND
        start(20);
        push_seg(8);
        tick();
        activate();
        wait_q(6);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_gate", o_txgate, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_mvalid", m_valid, 0);
        check("mrst_done", o_done, 0);
        check("mrst_err", o_err, 0);
        check("mrst_fcount", o_frame_count, 0);
        q.delete();
        tick();
        rst_n = 1'b1;
        exp_idx = src_idx;
        tick();
        check("post_rst_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
